// File: rtl/aes_cbc_dec_engine.sv
// AES-128 CBC decryption engine: packs key/ciphertext words, drives an external
// inverse-cipher core, XORs with the chain block and emits plaintext words.
// Optional macro AES_CBC_DEC_IV_LOAD_EN adds an iv_i port loaded on job start.
module aes_cbc_dec_engine #(
  parameter logic [127:0] IV          = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int           LEN_W       = 16,
  parameter int           KEXP_CYCLES = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Streams: a word moves on a cycle where valid and ready are both high;
  // valid never waits for ready, and the source holds data stable until taken.
  input  logic              ct_valid_i,
  input  logic [31:0]       ct_data_i,
  output logic              ct_ready_o,
  input  logic              key_valid_i,
  input  logic [31:0]       key_data_i,
  output logic              key_ready_o,
  output logic              pt_valid_o,
  output logic [31:0]       pt_data_o,
  output logic [3:0]        pt_strb_o,
  input  logic              pt_ready_i,
  input  logic              ctrl_start_i,
  input  logic              ctrl_clear_i,
  input  logic [LEN_W-1:0]  ctrl_len_i,
`ifdef AES_CBC_DEC_IV_LOAD_EN
  input  logic [127:0]      iv_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  blk_cnt_o,
  output logic              core_kld_o,
  output logic              core_ld_o,
  output logic [127:0]      core_key_o,
  output logic [127:0]      core_text_o,
  input  logic              core_done_i,
  input  logic [127:0]      core_text_i,
  output logic [2:0]        dbg_state_o
);

  localparam int KC_W = (KEXP_CYCLES > 1) ? $clog2(KEXP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_KEXP = 3'd2,
    S_CT   = 3'd3,
    S_LOAD = 3'd4,
    S_WAIT = 3'd5,
    S_EMIT = 3'd6,
    S_DONE = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] blk_cnt_q;
  logic [LEN_W-1:0] blk_nxt;
  logic [127:0]     key_q;
  logic [127:0]     ct_q;
  logic [127:0]     chain_q;
  logic [127:0]     res_q;
  logic [1:0]       kwc_q, cwc_q, ewc_q;
  logic [KC_W-1:0]  kcnt_q;
  logic             busy_q, done_q;

  assign blk_nxt = blk_cnt_q + LEN_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl_clear_i) state_q <= S_IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    key_ready_o = 1'b0;
    ct_ready_o  = 1'b0;
    pt_valid_o  = 1'b0;
    core_kld_o  = 1'b0;
    core_ld_o   = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_start_i) state_d = (ctrl_len_i == '0) ? S_DONE : S_KEY;
      S_KEY: begin
        key_ready_o = 1'b1;
        if (key_valid_i && kwc_q == 2'd3) state_d = S_KEXP;
      end
      S_KEXP: begin
        core_kld_o = (kcnt_q == '0);
        if (kcnt_q == KC_W'(KEXP_CYCLES - 1)) state_d = S_CT;
      end
      S_CT: begin
        ct_ready_o = 1'b1;
        if (ct_valid_i && cwc_q == 2'd3) state_d = S_LOAD;
      end
      S_LOAD: begin
        core_ld_o = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: if (core_done_i) state_d = S_EMIT;
      S_EMIT: begin
        pt_valid_o = 1'b1;
        if (pt_ready_i && ewc_q == 2'd3) state_d = (blk_nxt == len_q) ? S_DONE : S_CT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl_clear_i) begin
      len_q     <= '0;
      blk_cnt_q <= '0;
      key_q     <= '0;
      ct_q      <= '0;
      chain_q   <= IV;
      res_q     <= '0;
      kwc_q     <= '0;
      cwc_q     <= '0;
      ewc_q     <= '0;
      kcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: if (ctrl_start_i) begin
          len_q     <= ctrl_len_i;
          blk_cnt_q <= '0;
          busy_q    <= 1'b1;
          kwc_q     <= '0;
          cwc_q     <= '0;
          ewc_q     <= '0;
`ifdef AES_CBC_DEC_IV_LOAD_EN
          chain_q   <= iv_i;
`endif
        end
        S_KEY: begin
          kcnt_q <= '0;
          if (key_valid_i) begin
            key_q <= {key_q[95:0], key_data_i};
            kwc_q <= kwc_q + 2'd1;
          end
        end
        S_KEXP: kcnt_q <= kcnt_q + KC_W'(1);
        S_CT: if (ct_valid_i) begin
          ct_q  <= {ct_q[95:0], ct_data_i};
          cwc_q <= cwc_q + 2'd1;
        end
        // The block just decrypted becomes the chain value for the next one.
        S_WAIT: if (core_done_i) begin
          res_q   <= core_text_i ^ chain_q;
          chain_q <= ct_q;
          ewc_q   <= '0;
        end
        S_EMIT: if (pt_ready_i) begin
          res_q <= {res_q[95:0], 32'h0};
          ewc_q <= ewc_q + 2'd1;
          if (ewc_q == 2'd3) blk_cnt_q <= blk_nxt;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
`ifndef AES_CBC_DEC_IV_LOAD_EN
          chain_q <= IV;
`endif
        end
        default: ;
      endcase
    end
  end

  assign pt_data_o   = res_q[127:96];
  assign pt_strb_o   = 4'hF;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign blk_cnt_o   = blk_cnt_q;
  assign core_key_o  = key_q;
  assign core_text_o = ct_q;
  assign dbg_state_o = state_q;

endmodule
